seg7_scan_decoder: RTL



---
 rtl/seg7_scan_decoder.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_decoder.sv
// Display monitor: recovers hex nibbles from a scanned, active-low 7-segment drive bus.
// Define SEG7_TIMEOUT_EN to build per-digit staleness counters that expire valid/blank.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS     = 4,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] hex_out,
  output logic [NUM_DIGITS-1:0]   valid,
  output logic [NUM_DIGITS-1:0]   blank,
  output logic                    err,
  output logic                    upd,
  output logic [2:0]              upd_idx
);

  // state   | meaning
  // IDLE    | digit select zero or multi-hot, counter parked at 0
  // COUNT   | one-hot sample seen, counting identical consecutive samples
  // CAPTURE | stable pattern present for STABLE_CYCLES, decode into its digit
  // HOLD    | captured, waiting for the sample to change
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] COUNT   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;
  localparam logic [1:0] HOLD    = 2'd3;

  localparam logic [7:0] STABLE_CNT = 8'(STABLE_CYCLES);

  logic [6:0]            seg_q, seg_p;
  logic [NUM_DIGITS-1:0] dig_q, dig_p;
  logic [1:0]            state, state_n;
  logic [7:0]            cnt, cnt_n;
  logic                  cap, same, dig_ok, known, is_blank;
  logic [4:0]            dec;
  logic [2:0]            cap_idx;

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

  function automatic logic [2:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (v[i]) idx = 3'(i);
    return idx;
  endfunction

  // {known, nibble}; blank and unknown codes both return known=0
  function automatic logic [4:0] decode(input logic [6:0] s);
    logic [4:0] r;
    r = 5'h00;
    case (s)
      7'h40: r = 5'h10;  7'h79: r = 5'h11;  7'h24: r = 5'h12;  7'h30: r = 5'h13;
      7'h19: r = 5'h14;  7'h12: r = 5'h15;  7'h02: r = 5'h16;  7'h78: r = 5'h17;
      7'h00: r = 5'h18;  7'h10: r = 5'h19;  7'h08: r = 5'h1A;  7'h03: r = 5'h1B;
      7'h46: r = 5'h1C;  7'h21: r = 5'h1D;  7'h06: r = 5'h1E;  7'h0E: r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  assign same     = (seg_q == seg_p) && (dig_q == dig_p);
  assign dig_ok   = is_onehot(dig_q);
  // seg_p/dig_p hold the last sample that was proven stable when CAPTURE is active
  assign dec      = decode(seg_p);
  assign known    = dec[4];
  assign is_blank = (seg_p == 7'h7F);
  assign cap_idx  = onehot_idx(dig_p);

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cap     = 1'b0;
    if (!dig_ok) begin
      state_n = IDLE;
      cnt_n   = 8'd0;
    end else begin
      case (state)
        IDLE: begin
          state_n = COUNT;
          cnt_n   = 8'd1;
        end
        COUNT: begin
          if (same) cnt_n = (cnt == 8'hFF) ? cnt : cnt + 8'd1;
          else      cnt_n = 8'd1;
          if (cnt_n >= STABLE_CNT) state_n = CAPTURE;
        end
        CAPTURE: begin
          cap = 1'b1;
          // a change landing on the capture edge starts a new count rather than being lost in HOLD
          if (same) begin
            state_n = HOLD;
          end else begin
            state_n = COUNT;
            cnt_n   = 8'd1;
          end
        end
        default: begin
          if (!same) begin
            state_n = COUNT;
            cnt_n   = 8'd1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_q <= '0;
      seg_p <= '0;
      dig_q <= '0;
      dig_p <= '0;
      state <= IDLE;
      cnt   <= '0;
    end else begin
      seg_q <= seg_in;
      seg_p <= seg_q;
      dig_q <= dig_en;
      dig_p <= dig_q;
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

`ifdef SEG7_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] stale [NUM_DIGITS];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_out <= '0;
      valid   <= '0;
      blank   <= '0;
      err     <= 1'b0;
      upd     <= 1'b0;
      upd_idx <= 3'd0;
`ifdef SEG7_TIMEOUT_EN
      for (int i = 0; i < NUM_DIGITS; i++) stale[i] <= '0;
`endif
    end else begin
      upd <= cap;
      err <= cap && !known && !is_blank;
      if (cap) upd_idx <= cap_idx;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (cap && dig_p[i]) begin
          if (known) begin
            hex_out[4*i +: 4] <= dec[3:0];
            valid[i]          <= 1'b1;
            blank[i]          <= 1'b0;
          end else begin
            valid[i] <= 1'b0;
            blank[i] <= is_blank;
          end
`ifdef SEG7_TIMEOUT_EN
          stale[i] <= '0;
        end else if (stale[i] != TW'(TIMEOUT_CYCLES)) begin
          stale[i] <= stale[i] + 1'b1;
          if (stale[i] == TW'(TIMEOUT_CYCLES - 1)) begin
            valid[i] <= 1'b0;
            blank[i] <= 1'b0;
          end
`endif
        end
      end
    end
  end

endmodule
